// File: rtl/decode_phase_miinst_supply_queue.sv
// Micro-instruction supply queue between x86 translate and decode.
// Accepts 0-2 miinsts per cycle, presents the oldest entry to decode, and flushes in one cycle.
package decode_phase_miinst_pkg;
  typedef enum logic [3:0] {
    MIOP_NOP    = 4'd0,
    MIOP_ALU    = 4'd1,
    MIOP_LOAD   = 4'd2,
    MIOP_STORE  = 4'd3,
    MIOP_BRANCH = 4'd4,
    MIOP_MUL    = 4'd5
  } miop_e;

  typedef struct packed {
    miop_e       op;
    logic [4:0]  d;
    logic [4:0]  s;
    logic [4:0]  t;
    logic [15:0] imm;
    logic [2:0]  bmd;
    logic [31:0] pc;
  } miinst_t;

  localparam miinst_t MIINST_NOP = '{op: MIOP_NOP, d: 5'd0, s: 5'd0, t: 5'd0,
                                     imm: 16'd0, bmd: 3'd0, pc: 32'd0};
endpackage

module decode_phase_miinst_supply_queue
  import decode_phase_miinst_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic [1:0]     enq_n,
  input  miinst_t        enq_miinst_0,
  input  miinst_t        enq_miinst_1,
  output logic           enq_ready,
  output miinst_t        deq_miinst_head,
  output logic           valid,
  input  logic           stall,
  input  logic           flush,
  output logic [PTR_W:0] count
);

  // enq_ready requires room for a full pair, so DEPTH-1 occupancy also blocks
  localparam logic [PTR_W:0] READY_MAX = (PTR_W+1)'(DEPTH - 2);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [1:0]       enq_acc;
  logic             do_deq;
  miinst_t          mem [DEPTH];

  assign enq_ready       = (count <= READY_MAX);
  assign valid           = (count != '0);
  assign deq_miinst_head = valid ? mem[rd_ptr] : MIINST_NOP;
  assign do_deq          = valid & ~stall & ~flush;

  // enq_n==3 is illegal and treated like a dropped write
  always_comb begin
    enq_acc = 2'd0;
    if (enq_ready && !flush && enq_n != 2'd3)
      enq_acc = enq_n;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PTR_W'(enq_acc);
      rd_ptr <= rd_ptr + PTR_W'(do_deq);
      count  <= count + (PTR_W+1)'(enq_acc) - (PTR_W+1)'(do_deq);
    end
  end

  // storage is deliberately left unreset; valid masks stale contents
  always_ff @(posedge clk) begin
    if (enq_acc != 2'd0)
      mem[wr_ptr] <= enq_miinst_0;
    if (enq_acc == 2'd2)
      mem[wr_ptr + PTR_W'(1)] <= enq_miinst_1;
  end

endmodule
